l15_inv_fwd_responder: RTL
==========================

# l15_inv_fwd_responder

NoC2→NoC3 responder on the L1.5 side of the L2 coherence protocol. It receives L2-originated NoC2 messages, and for each INV_FWD it issues a one-cycle local invalidate pulse and returns an INV_FWDACK on NoC3 to the requesting L2 home. All other NoC2 message types are consumed and counted. It is the peer agent used opposite the L2 in INV_FWD/INV_FWDACK end-to-end checks.

## Interface
- ACK_DEPTH, 2: pending-ack queue entries (power of two, ≥1)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- chipid  in  14  own chip id, used in the ack source flit
- coreid_x  in  8  own X, used in the ack source flit
- coreid_y  in  8  own Y, used in the ack source flit
- noc2_valid_in  in  1  NoC2 flit valid
- noc2_data_in  in  64  NoC2 flit
- noc2_ready_in  out  1  NoC2 flit accepted when valid&&ready
- noc3_valid_out  out  1  NoC3 flit valid
- noc3_data_out  out  64  NoC3 flit
- noc3_ready_out  in  1  NoC3 sink ready
- inv_req_valid  out  1  one-cycle local invalidate pulse
- inv_req_addr  out  40  line address for inv_req_valid
- inv_count  out  16  INV_FWDs accepted, saturating at 16'hFFFF
- drop_count  out  16  non-INV_FWD messages consumed, wrapping

## Operation
- Header flit (flit0) fields: [63:50] dst chipid, [49:42] dst x, [41:34] dst y, [33:30] fbits, [29:22] payload length (flits after the header), [21:14] msg type, [13:6] mshrid, [5:0] options.
- Flit1: [39:0] address. Flit2: [63:50] src chipid, [49:42] src x, [41:34] src y, [33:30] src fbits.
- RX FSM: RX_HDR → RX_ADDR → RX_SRC → RX_SKIP.
  - In RX_HDR, latch type and mshrid, and set rem = payload length. If len = 0, stay in RX_HDR.
  - Each accepted flit decrements rem. When rem reaches 0 on acceptance, return to RX_HDR from any state.
  - If rem > 0 after RX_SRC, go to RX_SKIP and discard flits until rem = 0.
- INV_FWD is committed on acceptance of its flit2 (RX_SRC). On that cycle:
  - push {src chipid/x/y/fbits, mshrid, addr} into the ack queue;
  - set inv_req_valid = 1 and inv_req_addr = addr for exactly that cycle;
  - increment inv_count.
- An INV_FWD with len < 2 is malformed. It is consumed and counted in drop_count, with no ack and no pulse.
- Every other type increments drop_count on header acceptance.
- noc2_ready_in = 0 only when rx_state = RX_SRC, the latched type is INV_FWD, and the queue is full. Otherwise it is 1. A pop in the same cycle does not relieve full (no bypass).
- TX FSM: TX_IDLE → TX_HDR → TX_ADDR → TX_SRC → TX_IDLE (or back to TX_HDR if the queue is non-empty after the pop). The queue head is popped when the TX_SRC flit is accepted.
- Ack flit0:
  - dst = request src chipid/x/y;
  - fbits = request src fbits;
  - len = 8'd2;
  - type = INV_FWDACK;
  - mshrid echoed;
  - options = 0.
- Ack flit1: {24'b0, addr}.
- Ack flit2: {chipid, coreid_x, coreid_y, 4'b0, 30'b0}.
- Simultaneous push and pop on a non-full queue: both take effect and the occupancy is unchanged.

## Timing
- Reset values: noc2_ready_in = 1, noc3_valid_out = 0, noc3_data_out = 0, inv_req_valid = 0, inv_req_addr = 0, inv_count = 0, drop_count = 0. Both FSMs go to their idle or header state and the queue is empty.
- Ack latency: flit2 accepted at cycle N → ack flit0 valid at N+1 when the queue was empty.
- Back-to-back acks: the next flit0 follows its predecessor's flit2 acceptance with no bubble.
- noc3_valid_out and noc3_data_out are registered. They are held stable until noc3_ready_out, and valid never drops without a handshake.
- Reset mid-operation clears everything in one cycle. Partial RX messages and in-flight acks are discarded, and no flit is resumed.

## Structure
- Package l15_noc_pkg: header bit-position constants, MSG_TYPE_INV_FWD = 8'd18, MSG_TYPE_INV_FWDACK = 8'd21, ack_entry_t struct, and rx/tx state enums.
- Sub-module l15_ack_fifo: synchronous FIFO of ack_entry_t, depth ACK_DEPTH, with full/empty, push/pop, and same-cycle push+pop.

## Test plan
- INV_FWD with len 2, src (14'h3, 8'h1, 8'h2), mshrid 8'h2A, addr 40'h12_3456_7880, noc3_ready_out held at 1 → response:
  - inv_req_valid is a one-cycle pulse on the flit2 cycle, with that addr;
  - flit0 = {14'h3, 8'h1, 8'h2, 4'h0, 8'd2, 8'd21, 8'h2A, 6'h0}, emitted at N+1;
  - flits 1 and 2 follow on consecutive cycles;
  - inv_count = 1.
- Three INV_FWDs back-to-back with noc3_ready_out held at 0 → response:
  - noc2_ready_in drops at the third message's flit2;
  - after ready rises, three acks are emitted with mshrids in order and nothing lost.
- INV_FWD with len 4 → response: the two extra flits are skipped, one ack, and RX returns to RX_HDR.
- Non-INV type with len 3 → response: four flits consumed, drop_count = 1, no ack, no pulse.
- rst_n = 0 during ack flit1 → response: the next cycle noc3_valid_out = 0, both counters are 0, and no stale flit appears after release.
- inv_count preset to 16'hFFFE, then three INV_FWDs → inv_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/l15_noc_pkg.sv
// l15_noc_pkg
//   Shared definitions for the L1.5-side INV_FWD responder:
//   NoC header bit positions, message type codes, the pending-ack
//   entry layout, RX/TX state encodings and the ack header builder.
package l15_noc_pkg;

   // Header flit (flit0) field positions
   localparam int unsigned HDR_CHIPID_MSB = 63;
   localparam int unsigned HDR_CHIPID_LSB = 50;
   localparam int unsigned HDR_X_MSB      = 49;
   localparam int unsigned HDR_X_LSB      = 42;
   localparam int unsigned HDR_Y_MSB      = 41;
   localparam int unsigned HDR_Y_LSB      = 34;
   localparam int unsigned HDR_FBITS_MSB  = 33;
   localparam int unsigned HDR_FBITS_LSB  = 30;
   localparam int unsigned HDR_LEN_MSB    = 29;
   localparam int unsigned HDR_LEN_LSB    = 22;
   localparam int unsigned HDR_TYPE_MSB   = 21;
   localparam int unsigned HDR_TYPE_LSB   = 14;
   localparam int unsigned HDR_MSHR_MSB   = 13;
   localparam int unsigned HDR_MSHR_LSB   = 6;
   localparam int unsigned ADDR_MSB       = 39;

   localparam logic [7:0] MSG_TYPE_INV_FWD    = 8'd18;
   localparam logic [7:0] MSG_TYPE_INV_FWDACK = 8'd21;
   localparam logic [7:0] ACK_PAYLOAD_LEN     = 8'd2;

   typedef struct packed {
      logic [13:0] chipid;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [3:0]  fbits;
      logic [7:0]  mshrid;
      logic [39:0] addr;
   } ack_entry_t;

   typedef enum logic [1:0] {RX_HDR, RX_ADDR, RX_SRC, RX_SKIP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_ADDR, TX_SRC} tx_state_e;

   // INV_FWDACK header addressed back to the requesting L2 home
   function automatic logic [63:0] ack_hdr(input ack_entry_t e);
      return {e.chipid, e.x, e.y, e.fbits, ACK_PAYLOAD_LEN,
              MSG_TYPE_INV_FWDACK, e.mshrid, 6'b0};
   endfunction

endpackage

// File: rtl/l15_ack_fifo.sv
// l15_ack_fifo
//   Synchronous FIFO of pending INV_FWDACK entries.
//   Ports: clk, rst_n (sync, active low), push_i/push_data_i,
//   pop_i, next_o (entry behind the head), full_o, empty_o,
//   multi_o (two or more entries held).
//   Same-cycle push and pop on a non-full FIFO leaves occupancy unchanged.
module l15_ack_fifo
   import l15_noc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  ack_entry_t push_data_i,
   input  logic       pop_i,
   output ack_entry_t next_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       multi_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   ack_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign multi_o = (count_q > CW'(1));
   assign next_o  = mem_q[ptr_inc(rd_ptr_q)];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/l15_inv_fwd_responder.sv
// l15_inv_fwd_responder
//   L1.5-side NoC2->NoC3 responder. Each well-formed INV_FWD raises a
//   one-cycle local invalidate and queues an INV_FWDACK back to its L2
//   home; all other NoC2 messages are consumed and counted.
//   Ports:
//     clk, rst_n                      clock, sync active-low reset
//     chipid, coreid_x, coreid_y      own location, placed in ack flit2
//     noc2_valid_in/data_in/ready_in  inbound NoC2 flits
//     noc3_valid_out/data_out/ready_out outbound NoC3 flits (registered)
//     inv_req_valid, inv_req_addr     local invalidate pulse
//     inv_count                       accepted INV_FWDs, saturating
//     drop_count                      consumed non-INV_FWD messages, wrapping
module l15_inv_fwd_responder
   import l15_noc_pkg::*;
#(
   parameter int unsigned ACK_DEPTH     = 2,
   parameter logic [15:0] INV_COUNT_RST = '0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] chipid,
   input  logic [7:0]  coreid_x,
   input  logic [7:0]  coreid_y,
   input  logic        noc2_valid_in,
   input  logic [63:0] noc2_data_in,
   output logic        noc2_ready_in,
   output logic        noc3_valid_out,
   output logic [63:0] noc3_data_out,
   input  logic        noc3_ready_out,
   output logic        inv_req_valid,
   output logic [39:0] inv_req_addr,
   output logic [15:0] inv_count,
   output logic [15:0] drop_count
);

   rx_state_e   rx_q, rx_d;
   logic [7:0]  rem_q, rem_d, rem_dec;
   logic [7:0]  type_q, type_d;
   logic [7:0]  mshr_q, mshr_d;
   logic [39:0] addr_q, addr_d;
   logic [15:0] inv_cnt_q, inv_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   tx_state_e   tx_q, tx_d;
   logic [63:0] data_q, data_d;
   ack_entry_t  cur_q, cur_d;

   logic        rx_ready, rx_acc, push, pop;
   logic        fifo_full, fifo_empty, fifo_multi;
   ack_entry_t  push_entry, fifo_next;
   logic [7:0]  hdr_len, hdr_type;

   assign hdr_len  = noc2_data_in[HDR_LEN_MSB:HDR_LEN_LSB];
   assign hdr_type = noc2_data_in[HDR_TYPE_MSB:HDR_TYPE_LSB];
   assign rem_dec  = rem_q - 8'd1;

   // Backpressure only where a push is due; a same-cycle pop does not count
   assign rx_ready = !((rx_q == RX_SRC) && (type_q == MSG_TYPE_INV_FWD) && fifo_full);
   assign rx_acc   = noc2_valid_in && rx_ready;

   assign push_entry = '{chipid: noc2_data_in[HDR_CHIPID_MSB:HDR_CHIPID_LSB],
                         x:      noc2_data_in[HDR_X_MSB:HDR_X_LSB],
                         y:      noc2_data_in[HDR_Y_MSB:HDR_Y_LSB],
                         fbits:  noc2_data_in[HDR_FBITS_MSB:HDR_FBITS_LSB],
                         mshrid: mshr_q,
                         addr:   addr_q};

   always_comb begin
      rx_d       = rx_q;
      rem_d      = rem_q;
      type_d     = type_q;
      mshr_d     = mshr_q;
      addr_d     = addr_q;
      inv_cnt_d  = inv_cnt_q;
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;
      if (rx_acc) begin
         case (rx_q)
            RX_HDR: begin
               type_d = hdr_type;
               mshr_d = noc2_data_in[HDR_MSHR_MSB:HDR_MSHR_LSB];
               rem_d  = hdr_len;
               rx_d   = (hdr_len == 8'd0) ? RX_HDR : RX_ADDR;
               // A short INV_FWD never reaches RX_SRC, so it is a drop
               if ((hdr_type != MSG_TYPE_INV_FWD) || (hdr_len < 8'd2))
                  drop_cnt_d = drop_cnt_q + 16'd1;
            end
            RX_ADDR: begin
               addr_d = noc2_data_in[ADDR_MSB:0];
               rem_d  = rem_dec;
               rx_d   = (rem_dec == 8'd0) ? RX_HDR : RX_SRC;
            end
            RX_SRC: begin
               rem_d = rem_dec;
               rx_d  = (rem_dec == 8'd0) ? RX_HDR : RX_SKIP;
               if (type_q == MSG_TYPE_INV_FWD) begin
                  push = 1'b1;
                  if (inv_cnt_q != '1) inv_cnt_d = inv_cnt_q + 16'd1;
               end
            end
            RX_SKIP: begin
               rem_d = rem_dec;
               if (rem_dec == 8'd0) rx_d = RX_HDR;
            end
            default: rx_d = RX_HDR;
         endcase
      end
   end

   l15_ack_fifo #(
      .DEPTH (ACK_DEPTH)
   ) u_ack_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .next_o      (fifo_next),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .multi_o     (fifo_multi)
   );

   // cur_q mirrors the FIFO head (popped only after flit2) so the next
   // header can be loaded from the push path or the second entry without
   // a bubble.
   always_comb begin
      tx_d   = tx_q;
      data_d = data_q;
      cur_d  = cur_q;
      pop    = 1'b0;
      case (tx_q)
         TX_IDLE: begin
            if (push && fifo_empty) begin
               cur_d  = push_entry;
               data_d = ack_hdr(push_entry);
               tx_d   = TX_HDR;
            end
         end
         TX_HDR: begin
            if (noc3_ready_out) begin
               data_d = {24'b0, cur_q.addr};
               tx_d   = TX_ADDR;
            end
         end
         TX_ADDR: begin
            if (noc3_ready_out) begin
               data_d = {chipid, coreid_x, coreid_y, 4'b0, 30'b0};
               tx_d   = TX_SRC;
            end
         end
         TX_SRC: begin
            if (noc3_ready_out) begin
               pop = 1'b1;
               if (fifo_multi) begin
                  cur_d  = fifo_next;
                  data_d = ack_hdr(fifo_next);
                  tx_d   = TX_HDR;
               end else if (push) begin
                  cur_d  = push_entry;
                  data_d = ack_hdr(push_entry);
                  tx_d   = TX_HDR;
               end else begin
                  tx_d = TX_IDLE;
               end
            end
         end
         default: tx_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_q       <= RX_HDR;
         rem_q      <= '0;
         type_q     <= '0;
         mshr_q     <= '0;
         addr_q     <= '0;
         inv_cnt_q  <= INV_COUNT_RST;
         drop_cnt_q <= '0;
         tx_q       <= TX_IDLE;
         data_q     <= '0;
         cur_q      <= '0;
      end else begin
         rx_q       <= rx_d;
         rem_q      <= rem_d;
         type_q     <= type_d;
         mshr_q     <= mshr_d;
         addr_q     <= addr_d;
         inv_cnt_q  <= inv_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         tx_q       <= tx_d;
         data_q     <= data_d;
         cur_q      <= cur_d;
      end
   end

   assign noc2_ready_in  = rx_ready;
   assign noc3_valid_out = (tx_q != TX_IDLE);
   assign noc3_data_out  = data_q;
   assign inv_req_valid  = push;
   assign inv_req_addr   = push ? addr_q : '0;
   assign inv_count      = inv_cnt_q;
   assign drop_count     = drop_cnt_q;

endmodule
